// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: control codes, FSM states
// and small decode helpers used by both the arbiter and alu32.
package alu_share_arbiter_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_NOR  = 4'b1001;
  localparam logic [3:0] ALU_NAND = 4'b1100;
  localparam logic [3:0] ALU_XOR  = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // True for any of the seven control codes the ALU implements.
  function automatic logic is_legal(input logic [3:0] ctrl);
    case (ctrl)
      ALU_AND, ALU_OR, ALU_ADD, ALU_SUB,
      ALU_NOR, ALU_NAND, ALU_XOR: is_legal = 1'b1;
      default:                    is_legal = 1'b0;
    endcase
  endfunction

  // True only for the operations that are allowed to touch the flags.
  function automatic logic is_arith(input logic [3:0] ctrl);
    is_arith = (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arbiter_alu32.sv
// Purely combinational 32-bit ALU. Illegal control codes produce a zero
// result and no overflow; n and z always describe the result bus.
module alu32
  import alu_share_arbiter_pkg::*;
(
  output logic [31:0] result,
  output logic        v,
  output logic        n,
  output logic        z,
  input  logic [31:0] op1,
  input  logic [31:0] op2,
  input  logic [3:0]  ctrl
);

  logic [31:0] sum;
  logic [31:0] diff;

  assign sum  = op1 + op2;
  assign diff = op1 - op2;

  // Select the operation; overflow is only meaningful for ADD and SUB.
  always_comb begin
    result = '0;
    v      = 1'b0;
    case (ctrl)
      ALU_AND:  result = op1 & op2;
      ALU_OR:   result = op1 | op2;
      ALU_ADD: begin
        result = sum;
        v      = (op1[31] == op2[31]) && (sum[31] != op1[31]);
      end
      ALU_SUB: begin
        result = diff;
        v      = (op1[31] != op2[31]) && (diff[31] != op1[31]);
      end
      ALU_NOR:  result = ~(op1 | op2);
      ALU_NAND: result = ~(op1 & op2);
      ALU_XOR:  result = op1 ^ op2;
      default: begin
        result = '0;
        v      = 1'b0;
      end
    endcase
  end

  assign n = result[31];
  assign z = (result == 32'd0);

endmodule

// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single shared alu32. Arbitrates, captures
// operands, evaluates for one cycle and holds the response until consumed.
// Also owns the architectural V/N/Z flags, which only ADD/SUB may change.
module alu_share_arbiter
  import alu_share_arbiter_pkg::*;
#(
  parameter int         WIDTH    = 32,
  parameter bit         FAIR     = 1'b1,
  parameter logic [2:0] FLAG_RST = 3'b000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_op1,
  input  logic [WIDTH-1:0] req0_op2,
  input  logic [3:0]       req0_ctrl,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_op1,
  input  logic [WIDTH-1:0] req1_op2,
  input  logic [3:0]       req1_ctrl,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_err,
  output logic             flag_v,
  output logic             flag_n,
  output logic             flag_z
);

  state_t           state;
  logic             last_grant;
  logic [WIDTH-1:0] op1_q;
  logic [WIDTH-1:0] op2_q;
  logic [3:0]       ctrl_q;
  logic             id_q;

  logic             any_valid;
  logic             grant_id;

  logic [WIDTH-1:0] alu_result;
  logic             alu_v;
  logic             alu_n;
  logic             alu_z;

  alu32 u_alu (
    .result (alu_result),
    .v      (alu_v),
    .n      (alu_n),
    .z      (alu_z),
    .op1    (op1_q),
    .op2    (op2_q),
    .ctrl   (ctrl_q)
  );

  // Pick the winner: a lone requester always wins; on conflict alternate
  // against the last grant, or favour requester 0 when fairness is off.
  always_comb begin
    any_valid = req0_valid || req1_valid;
    grant_id  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = FAIR ? !last_grant : 1'b0;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  assign req0_ready = (state == ST_IDLE) && !reset && any_valid && !grant_id;
  assign req1_ready = (state == ST_IDLE) && !reset && any_valid && grant_id;

  // Sequence accept, evaluate and respond; reset drops any in-flight op.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      op1_q      <= '0;
      op2_q      <= '0;
      ctrl_q     <= ALU_AND;
      id_q       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_err    <= 1'b0;
      {flag_v, flag_n, flag_z} <= FLAG_RST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (any_valid) begin
            op1_q      <= grant_id ? req1_op1  : req0_op1;
            op2_q      <= grant_id ? req1_op2  : req0_op2;
            ctrl_q     <= grant_id ? req1_ctrl : req0_ctrl;
            id_q       <= grant_id;
            last_grant <= grant_id;
            state      <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          rsp_result <= alu_result;
          rsp_err    <= !is_legal(ctrl_q);
          rsp_id     <= id_q;
          rsp_valid  <= 1'b1;
          if (is_arith(ctrl_q)) begin
            {flag_v, flag_n, flag_z} <= {alu_v, alu_n, alu_z};
          end
          state      <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter: a table of single operations with
// hand-computed results and flags, plus hand-written arbitration,
// backpressure and reset sequences. A fixed-priority copy checks FAIR=0.
module tb_alu_share_arbiter;
  import alu_share_arbiter_pkg::*;

  typedef struct {
    logic        id;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  ctrl;
    logic [31:0] exp_result;
    logic        exp_err;
    logic [2:0]  exp_flags;
  } vector_t;

  logic        clk;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [31:0] rsp_result;
  logic        flag_v, flag_n, flag_z;

  logic        fp_req0_valid, fp_req0_ready, fp_req1_valid, fp_req1_ready;
  logic [31:0] fp_req0_op1, fp_req0_op2, fp_req1_op1, fp_req1_op2;
  logic [3:0]  fp_req0_ctrl, fp_req1_ctrl;
  logic        fp_rsp_valid, fp_rsp_ready, fp_rsp_id, fp_rsp_err;
  logic [31:0] fp_rsp_result;
  logic        fp_flag_v, fp_flag_n, fp_flag_z;

  int n_checks;
  int n_fail;

  vector_t vecs [13];

  alu_share_arbiter #(.WIDTH(32), .FAIR(1'b1), .FLAG_RST(3'b000)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op1   (req0_op1),
    .req0_op2   (req0_op2),
    .req0_ctrl  (req0_ctrl),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op1   (req1_op1),
    .req1_op2   (req1_op2),
    .req1_ctrl  (req1_ctrl),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err),
    .flag_v     (flag_v),
    .flag_n     (flag_n),
    .flag_z     (flag_z)
  );

  alu_share_arbiter #(.WIDTH(32), .FAIR(1'b0), .FLAG_RST(3'b000)) dut_fp (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (fp_req0_valid),
    .req0_ready (fp_req0_ready),
    .req0_op1   (fp_req0_op1),
    .req0_op2   (fp_req0_op2),
    .req0_ctrl  (fp_req0_ctrl),
    .req1_valid (fp_req1_valid),
    .req1_ready (fp_req1_ready),
    .req1_op1   (fp_req1_op1),
    .req1_op2   (fp_req1_op2),
    .req1_ctrl  (fp_req1_ctrl),
    .rsp_valid  (fp_rsp_valid),
    .rsp_ready  (fp_rsp_ready),
    .rsp_id     (fp_rsp_id),
    .rsp_result (fp_rsp_result),
    .rsp_err    (fp_rsp_err),
    .flag_v     (fp_flag_v),
    .flag_n     (fp_flag_n),
    .flag_z     (fp_flag_z)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value and log misses.
  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Issue one op on a single requester and check ready, latency and response.
  task automatic apply_stimulus(input vector_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    @(negedge clk);
    rsp_ready = 1'b1;
    if (v.id) begin
      req1_valid = 1'b1; req1_op1 = v.op1; req1_op2 = v.op2; req1_ctrl = v.ctrl;
    end else begin
      req0_valid = 1'b1; req0_op1 = v.op1; req0_op2 = v.op2; req0_ctrl = v.ctrl;
    end
    #1;
    check_output({tag, "_ready_win"},  v.id ? req1_ready : req0_ready, 32'd1);
    check_output({tag, "_ready_lose"}, v.id ? req0_ready : req1_ready, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    check_output({tag, "_exec_valid"}, rsp_valid, 32'd0);
    @(negedge clk);
    check_output({tag, "_rsp_valid"},  rsp_valid, 32'd1);
    check_output({tag, "_rsp_id"},     rsp_id, v.id);
    check_output({tag, "_rsp_result"}, rsp_result, v.exp_result);
    check_output({tag, "_rsp_err"},    rsp_err, v.exp_err);
    check_output({tag, "_flags"},      {flag_v, flag_n, flag_z}, v.exp_flags);
  endtask

  // Pulse reset for one rising edge with all requests idle.
  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    fp_req0_valid = 1'b0; fp_req1_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // {id, op1, op2, ctrl, result, err, {V,N,Z}} with flags cumulative from reset
    vecs[0]  = '{1'b0, 32'h0000ffff, 32'h00ff00ff, ALU_AND,  32'h000000ff, 1'b0, 3'b000};
    vecs[1]  = '{1'b1, 32'h7fffffff, 32'h7fffffff, ALU_ADD,  32'hfffffffe, 1'b0, 3'b110};
    vecs[2]  = '{1'b0, 32'h0000ffff, 32'h00ff00ff, ALU_XOR,  32'h00ffff00, 1'b0, 3'b110};
    vecs[3]  = '{1'b1, 32'h12340000, 32'h00005678, ALU_OR,   32'h12345678, 1'b0, 3'b110};
    vecs[4]  = '{1'b0, 32'd5,        32'd5,        ALU_SUB,  32'h00000000, 1'b0, 3'b001};
    vecs[5]  = '{1'b1, 32'h00000000, 32'h00000000, ALU_NOR,  32'hffffffff, 1'b0, 3'b001};
    vecs[6]  = '{1'b0, 32'hffffffff, 32'hffffffff, ALU_NAND, 32'h00000000, 1'b0, 3'b001};
    vecs[7]  = '{1'b0, 32'hffffffff, 32'h00000001, ALU_ADD,  32'h00000000, 1'b0, 3'b001};
    vecs[8]  = '{1'b1, 32'h80000000, 32'h00000001, ALU_SUB,  32'h7fffffff, 1'b0, 3'b100};
    vecs[9]  = '{1'b0, 32'h00000000, 32'h00000001, ALU_SUB,  32'hffffffff, 1'b0, 3'b010};
    vecs[10] = '{1'b1, 32'd5,        32'd5,        4'b0111,  32'h00000000, 1'b1, 3'b010};
    vecs[11] = '{1'b0, 32'd7,        32'd9,        4'b1111,  32'h00000000, 1'b1, 3'b010};
    vecs[12] = '{1'b0, 32'd1,        32'd2,        ALU_ADD,  32'h00000003, 1'b0, 3'b000};

    reset = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_op1 = '0; req0_op2 = '0; req0_ctrl = ALU_AND;
    req1_valid = 1'b0; req1_op1 = '0; req1_op2 = '0; req1_ctrl = ALU_AND;
    fp_rsp_ready = 1'b1;
    fp_req0_valid = 1'b0; fp_req0_op1 = '0; fp_req0_op2 = '0; fp_req0_ctrl = ALU_AND;
    fp_req1_valid = 1'b0; fp_req1_op1 = '0; fp_req1_op2 = '0; fp_req1_ctrl = ALU_AND;

    // Reset state, and a request raised during reset is not accepted
    repeat (2) @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b1;
    #1;
    check_output("reset_ready0", req0_ready, 32'd0);
    check_output("reset_rsp_valid", rsp_valid, 32'd0);
    check_output("reset_rsp_result", rsp_result, 32'd0);
    check_output("reset_rsp_err", rsp_err, 32'd0);
    check_output("reset_rsp_id", rsp_id, 32'd0);
    check_output("reset_flags", {flag_v, flag_n, flag_z}, 32'd0);
    req0_valid = 1'b0;
    reset = 1'b0;

    // Table of single-requester operations
    for (int i = 0; i < 13; i++) begin
      apply_stimulus(vecs[i], i);
    end

    // Conflict from reset: requester 0 first, then requester 1
    pulse_reset();
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 32'd10;        req0_op2 = 32'd10; req0_ctrl = ALU_SUB;
    req1_valid = 1'b1; req1_op1 = 32'hfffffff6;  req1_op2 = 32'd10; req1_ctrl = ALU_SUB;
    #1;
    check_output("rr1_ready0", req0_ready, 32'd1);
    check_output("rr1_ready1", req1_ready, 32'd0);
    @(negedge clk);
    check_output("rr1_exec_ready0", req0_ready, 32'd0);
    check_output("rr1_exec_ready1", req1_ready, 32'd0);
    check_output("rr1_exec_valid", rsp_valid, 32'd0);
    @(negedge clk);
    check_output("rr1_rsp_valid", rsp_valid, 32'd1);
    check_output("rr1_rsp_id", rsp_id, 32'd0);
    check_output("rr1_rsp_result", rsp_result, 32'd0);
    check_output("rr1_flags", {flag_v, flag_n, flag_z}, 32'b001);
    @(negedge clk);
    check_output("rr2_ready1", req1_ready, 32'd1);
    check_output("rr2_ready0", req0_ready, 32'd0);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("rr2_rsp_valid", rsp_valid, 32'd1);
    check_output("rr2_rsp_id", rsp_id, 32'd1);
    check_output("rr2_rsp_result", rsp_result, 32'hffffffec);
    check_output("rr2_flags", {flag_v, flag_n, flag_z}, 32'b010);

    // Fixed-priority instance: requester 0 wins twice while both are held
    @(negedge clk);
    fp_req0_valid = 1'b1; fp_req0_op1 = 32'hffffffff; fp_req0_op2 = 32'h0000abcd; fp_req0_ctrl = ALU_AND;
    fp_req1_valid = 1'b1; fp_req1_op1 = 32'd1;        fp_req1_op2 = 32'd2;        fp_req1_ctrl = ALU_OR;
    #1;
    check_output("fp1_ready0", fp_req0_ready, 32'd1);
    check_output("fp1_ready1", fp_req1_ready, 32'd0);
    @(negedge clk);
    @(negedge clk);
    check_output("fp1_rsp_valid", fp_rsp_valid, 32'd1);
    check_output("fp1_rsp_id", fp_rsp_id, 32'd0);
    check_output("fp1_rsp_result", fp_rsp_result, 32'h0000abcd);
    @(negedge clk);
    check_output("fp2_ready0", fp_req0_ready, 32'd1);
    check_output("fp2_ready1", fp_req1_ready, 32'd0);
    @(posedge clk);
    #1;
    fp_req0_valid = 1'b0;
    fp_req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("fp2_rsp_valid", fp_rsp_valid, 32'd1);
    check_output("fp2_rsp_id", fp_rsp_id, 32'd0);

    // Backpressure: response held for 5 cycles, no grants meanwhile
    @(negedge clk);
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_op1 = 32'h0f0f0f0f; req0_op2 = 32'hff00ff00; req0_ctrl = ALU_AND;
    #1;
    check_output("bp_ready0", req0_ready, 32'd1);
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_op1 = 32'd1; req1_op2 = 32'd2; req1_ctrl = ALU_OR;
    @(negedge clk);
    check_output("bp_exec_ready1", req1_ready, 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output($sformatf("bp%0d_rsp_valid", i), rsp_valid, 32'd1);
      check_output($sformatf("bp%0d_rsp_result", i), rsp_result, 32'h0f000f00);
      check_output($sformatf("bp%0d_rsp_id", i), rsp_id, 32'd0);
      check_output($sformatf("bp%0d_rsp_err", i), rsp_err, 32'd0);
      check_output($sformatf("bp%0d_ready0", i), req0_ready, 32'd0);
      check_output($sformatf("bp%0d_ready1", i), req1_ready, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check_output("bp_release_valid", rsp_valid, 32'd0);
    check_output("bp_release_ready1", req1_ready, 32'd1);
    @(posedge clk);
    #1;
    req1_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("bp_next_rsp_id", rsp_id, 32'd1);
    check_output("bp_next_rsp_result", rsp_result, 32'h00000003);
    check_output("bp_next_flags", {flag_v, flag_n, flag_z}, 32'b010);

    // Reset during EXEC drops the op and restores the flags
    @(negedge clk);
    req0_valid = 1'b1; req0_op1 = 32'h80000000; req0_op2 = 32'h80000000; req0_ctrl = ALU_ADD;
    @(posedge clk);
    #1;
    req0_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    req0_valid = 1'b1; req0_op1 = 32'h0000ffff; req0_op2 = 32'h00ff00ff; req0_ctrl = ALU_AND;
    #1;
    check_output("rst_exec_ready0", req0_ready, 32'd0);
    @(negedge clk);
    check_output("rst_exec_rsp_valid", rsp_valid, 32'd0);
    check_output("rst_exec_flags", {flag_v, flag_n, flag_z}, 32'b000);
    check_output("rst_exec_result", rsp_result, 32'd0);
    reset = 1'b0;
    req0_valid = 1'b0;
    apply_stimulus(vecs[0], 100);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Hard time limit so the bench always ends even if the DUT stalls
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish, expected finish before 100000");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one alu32 instance between two independent requesters using a valid/ready request channel per requester and one common response channel.
- Grants requesters round-robin and sequences operand capture, ALU evaluation and response hold.
- Owns the architectural V/N/Z flag register. The flags update only on ADD/SUB; logic ops leave them unchanged.
- Sits between the instruction-issue logic and the ALU in the datapath.

Parameters:
- WIDTH, 32: operand/result width. Must be 32 to match alu32.
- FAIR, 1: 1 = round-robin arbitration; 0 = fixed priority, requester 0 wins.
- FLAG_RST, 3'b000: reset value of {flag_v, flag_n, flag_z}.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- req0_valid  in  1  requester 0 has an operation
- req0_ready  out  1  requester 0 accepted this cycle
- req0_op1  in  WIDTH  operand 1
- req0_op2  in  WIDTH  operand 2
- req0_ctrl  in  4  ALU control code
- req1_valid, req1_ready, req1_op1, req1_op2, req1_ctrl: same as requester 0, for requester 1
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes response
- rsp_id  out  1  requester that issued the op
- rsp_result  out  WIDTH  ALU result
- rsp_err  out  1  control code was illegal
- flag_v, flag_n, flag_z  out  1 each  architectural flags (registered)

Behaviour:
- Legal codes: AND 0000, OR 0001, ADD 0010, SUB 0110, NOR 1001, NAND 1100, XOR 1101. All other codes are illegal.
- FSM states: IDLE, EXEC, RESP.
  - IDLE: arbitrate. If any reqN_valid is high, assert the winner's reqN_ready in the same cycle (combinational from valids and state). Latch op1, op2, ctrl and id into operand registers. Go to EXEC. Only the winner sees ready; the loser's ready stays 0.
  - EXEC: alu32 is driven from the operand registers. At the clock edge, capture the result into rsp_result, set rsp_err, update flags if ADD/SUB, go to RESP.
  - RESP: rsp_valid=1. rsp_id, rsp_result and rsp_err are held stable until rsp_valid && rsp_ready, then go to IDLE.
- Latency: accept at edge t, rsp_valid from t+2. Minimum issue interval is 3 cycles; there is no back-to-back acceptance in RESP even if rsp_ready=1.
- Arbitration with FAIR=1: a last_grant bit resets to 1, so requester 0 wins the first conflict. When both valids are high, grant !last_grant. A single valid is granted regardless of last_grant. last_grant updates only on acceptance.
- Illegal code: rsp_err=1, rsp_result=0, flags unchanged, still takes the EXEC and RESP path, so latency is unchanged.
- Flags on ADD/SUB:
  - V from alu32 v_flag (signed overflow).
  - N = result[31].
  - Z = (result==0).
  - Logic ops and illegal codes hold all three flags.
- Wrap-around: arithmetic is mod 2^32. Overflow is reported only via V and never saturates.
- Request inputs must stay stable while valid && !ready. The block does not check this.
- Reset: synchronous, overrides everything including mid-EXEC/RESP.
  - state=IDLE, rsp_valid=0, rsp_result=0, rsp_err=0, rsp_id=0, flags=FLAG_RST, last_grant=1, req*_ready=0 in the reset cycle.
  - An in-flight op is dropped with no response.
- Simultaneous reqN_valid with reset=1: not accepted.

Decomposition:
- Shared package/header alu_defs:
  - localparams for the 7 control codes (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_NOR, ALU_NAND, ALU_XOR).
  - FSM state encodings.
  - an is_legal / is_arith helper function.
- Sub-module: the existing alu32 is instantiated once (port order result, v, n, z, op1, op2, ctrl). No other sub-modules; arbiter and FSM stay inline.

Test Plan:
1. Reset, then req0: AND 0x0000ffff, 0x00ff00ff -> req0_ready same cycle; rsp_valid 2 cycles later with rsp_result=0x000000ff, rsp_id=0, rsp_err=0, flags stay 000.
2. req1: ADD 0x7fffffff + 0x7fffffff -> rsp_result=0xfffffffe, rsp_id=1, flags V=1 N=1 Z=0. A following XOR 0x0000ffff ^ 0x00ff00ff -> result 0x00ffff00, flags still 110.
3. Both valid, SUB 10-10 on req0 and SUB -10-10 on req1, held for 2 ops:
   - first response: id 0, result 0, Z=1.
   - second response: id 1, result 0xffffffec, N=1, Z=0.
   - with FAIR=0 and both held, requester 0 is granted twice.
4. Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and payload stable, both req_ready=0. Release -> IDLE next cycle, next grant the cycle after.
5. Illegal ctrl 4'b0111 with flags=010 -> rsp_err=1, result 0, flags stay 010, latency 2.
6. Assert reset in EXEC of ADD 0x80000000+0x80000000 -> no rsp_valid, flags=FLAG_RST, next request serviced normally by requester 0.
